calc_sequencer: RTL and testbench
=================================

Name: calc_sequencer

Overview:
- Central controller for the calculator datapath; replaces the free-running button FSM.
- Edge-detects the debounced BTNR/BTNL levels and walks the operand-load / opcode-select sequence.
- Latches both operands and the opcode, then drives a start/done handshake to a multi-cycle operation unit (add/sub/logic/multiply), with a timeout watchdog.
- Holds the result and state code for the display and LED logic.

Parameters:
- DATA_W, 8, operand width (width of sw and num1/num2).
- RES_W, 10, result width (ans, op_result).
- TIMEOUT, 255, maximum cycles spent in BUSY before ERROR; must be at least 1.
- NUM_OPS, 5, number of valid opcodes; opcodes >= NUM_OPS are illegal.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- btnr  in  1  debounced "advance" button, level.
- btnl  in  1  debounced "clear/abort" button, level.
- sw  in  DATA_W  switch value; sw[2:0] is the opcode in OP_SELECT.
- op_done  in  1  operation unit completion, 1-cycle pulse.
- op_result  in  RES_W  operation result, valid when op_done=1.
- op_err  in  1  operation unit error flag (overflow / illegal), valid with op_done.
- num1  out  DATA_W  latched first operand.
- num2  out  DATA_W  latched second operand.
- opcode  out  3  latched opcode.
- op_start  out  1  start pulse to the operation unit.
- ans  out  RES_W  latched result.
- state  out  3  current state code.
- err  out  1  high while in ERROR.

Behaviour:
- Clock and reset: one clock domain (clk). reset is synchronous and active-high; all registers update only on the rising edge of clk.
- Reset values: state=WAIT, num1=0, num2=0, opcode=0, ans=0, op_start=0, err=0, timeout counter=0.
- Button edge registers reset to 1, so a button held through reset produces no edge.
- Edge detect: r_edge = btnr & ~btnr_q and l_edge = btnl & ~btnl_q, where btnr_q/btnl_q are btnr/btnl registered one cycle. Holding a button yields exactly one edge.
- State codes: WAIT=0, LOAD_FIRST=1, LOAD_SECOND=2, OP_SELECT=3, BUSY=4, SHOW=5, ERROR=6. Code 7 is unreachable; if entered, the next cycle returns to WAIT.
- Priority: l_edge beats r_edge and op_done in the same cycle.
- l_edge in any state: next state is WAIT, operands and ans are held, and no op_start is issued. In BUSY, a later op_done is ignored.
- WAIT: r_edge -> LOAD_FIRST.
- LOAD_FIRST: r_edge -> num1<=sw, go to LOAD_SECOND.
- LOAD_SECOND: r_edge -> num2<=sw, go to OP_SELECT.
- OP_SELECT, on r_edge:
  - opcode<=sw[2:0].
  - If sw[2:0] < NUM_OPS: go to BUSY.
  - Otherwise: go to ERROR; op_start is never raised.
- op_start is high for exactly the first cycle in BUSY (registered, one cycle after the r_edge cycle).
- BUSY:
  - The counter increments every cycle.
  - op_done=1 and op_err=0 -> ans<=op_result, go to SHOW.
  - op_done=1 and op_err=1 -> ans unchanged, go to ERROR.
  - No op_done and counter==TIMEOUT -> ERROR.
  - The counter clears on BUSY entry.
  - op_done arriving in the op_start cycle is accepted (latency 0 is legal).
- SHOW: r_edge -> OP_SELECT (rerun with new opcode; operands retained).
- ERROR: err=1; r_edge -> WAIT.
- Outside BUSY: op_done is ignored.
- Reset mid-BUSY: return to reset values; the operation unit is not told to abort, and its pending op_done is ignored.
- num1, num2, opcode and ans change only at the events above.

Test Plan:
- Reset, then sequence: btnr (state 0->1), sw=8'h2A + btnr, sw=8'h15 + btnr, sw=3'd0 + btnr -> num1=2A, num2=15, opcode=0, state=4, single op_start the cycle after the edge. op_done with op_result=10'h03F three cycles later -> ans=03F, state=5.
- In OP_SELECT, sw[2:0]=6 + btnr -> state=6, err=1, op_start never asserted; next btnr -> state=0, err=0.
- In BUSY, withhold op_done, TIMEOUT=255 -> ERROR after exactly 256 BUSY cycles; op_done with op_err=1 in a separate run -> ERROR, ans unchanged.
- btnl and btnr rising in the same cycle while in LOAD_SECOND -> state=0, num2 unchanged. btnl during BUSY, then a late op_done -> stays in WAIT, ans unchanged.
- Hold btnr high for 100 cycles -> exactly one transition. Hold btnr through reset deassertion -> no transition out of WAIT.
- From SHOW, sw=3'd1 + btnr -> OP_SELECT. A further btnr -> BUSY with opcode=1 and num1/num2 retained. Assert reset in BUSY -> all outputs return to 0 the next cycle.

Source files
------------

// File: rtl/calc_sequencer.sv
// Calculator sequencer: edge-detects the advance/clear buttons, latches operands
// and opcode, and runs a start/done handshake with a timeout to the operation unit.
module calc_sequencer #(
    parameter int DATA_W  = 8,
    parameter int RES_W   = 10,
    parameter int TIMEOUT = 255,
    parameter int NUM_OPS = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btnr,
    input  logic              btnl,
    input  logic [DATA_W-1:0] sw,
    input  logic              op_done,
    input  logic [RES_W-1:0]  op_result,
    input  logic              op_err,
    output logic [DATA_W-1:0] num1,
    output logic [DATA_W-1:0] num2,
    output logic [2:0]        opcode,
    output logic              op_start,
    output logic [RES_W-1:0]  ans,
    output logic [2:0]        state,
    output logic              err
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [3:0]       NUM_OPS_C = 4'(NUM_OPS);

    typedef enum logic [2:0] {
        ST_WAIT        = 3'd0,
        ST_LOAD_FIRST  = 3'd1,
        ST_LOAD_SECOND = 3'd2,
        ST_OP_SELECT   = 3'd3,
        ST_BUSY        = 3'd4,
        ST_SHOW        = 3'd5,
        ST_ERROR       = 3'd6
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_btnr_q;
    logic              r_btnl_q;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_num1;
    logic [DATA_W-1:0] r_num2;
    logic [2:0]        r_opcode;
    logic [RES_W-1:0]  r_ans;
    logic              r_op_start;
    logic              r_err;

    logic w_r_edge;
    logic w_l_edge;
    logic w_op_legal;
    logic w_load1;
    logic w_load2;
    logic w_load_op;
    logic w_take_ans;
    logic w_enter_busy;

    assign w_r_edge   = btnr & ~r_btnr_q;
    assign w_l_edge   = btnl & ~r_btnl_q;
    assign w_op_legal = ({1'b0, sw[2:0]} < NUM_OPS_C);

    // Next-state and register-load decode; clear (l_edge) overrides everything.
    always_comb begin
        w_next       = r_state;
        w_load1      = 1'b0;
        w_load2      = 1'b0;
        w_load_op    = 1'b0;
        w_take_ans   = 1'b0;
        w_enter_busy = 1'b0;
        if (w_l_edge) begin
            w_next = ST_WAIT;
        end else begin
            case (r_state)
                ST_WAIT: begin
                    if (w_r_edge) begin
                        w_next = ST_LOAD_FIRST;
                    end else begin
                        w_next = ST_WAIT;
                    end
                end
                ST_LOAD_FIRST: begin
                    if (w_r_edge) begin
                        w_load1 = 1'b1;
                        w_next  = ST_LOAD_SECOND;
                    end else begin
                        w_next = ST_LOAD_FIRST;
                    end
                end
                ST_LOAD_SECOND: begin
                    if (w_r_edge) begin
                        w_load2 = 1'b1;
                        w_next  = ST_OP_SELECT;
                    end else begin
                        w_next = ST_LOAD_SECOND;
                    end
                end
                ST_OP_SELECT: begin
                    if (w_r_edge) begin
                        w_load_op = 1'b1;
                        if (w_op_legal) begin
                            w_enter_busy = 1'b1;
                            w_next       = ST_BUSY;
                        end else begin
                            w_next = ST_ERROR;
                        end
                    end else begin
                        w_next = ST_OP_SELECT;
                    end
                end
                ST_BUSY: begin
                    // A completion in the same cycle as the timeout still counts.
                    if (op_done) begin
                        if (op_err) begin
                            w_next = ST_ERROR;
                        end else begin
                            w_take_ans = 1'b1;
                            w_next     = ST_SHOW;
                        end
                    end else if (r_cnt == TIMEOUT_C) begin
                        w_next = ST_ERROR;
                    end else begin
                        w_next = ST_BUSY;
                    end
                end
                ST_SHOW: begin
                    if (w_r_edge) begin
                        w_next = ST_OP_SELECT;
                    end else begin
                        w_next = ST_SHOW;
                    end
                end
                ST_ERROR: begin
                    if (w_r_edge) begin
                        w_next = ST_WAIT;
                    end else begin
                        w_next = ST_ERROR;
                    end
                end
                default: begin
                    w_next = ST_WAIT;
                end
            endcase
        end
    end

    // State, button history and watchdog counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_WAIT;
            r_btnr_q <= 1'b1;
            r_btnl_q <= 1'b1;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_next;
            r_btnr_q <= btnr;
            r_btnl_q <= btnl;
            if (w_enter_busy) begin
                r_cnt <= '0;
            end else if (r_state == ST_BUSY) begin
                r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

    // Latched operands, opcode, result and the registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_num1     <= '0;
            r_num2     <= '0;
            r_opcode   <= 3'd0;
            r_ans      <= '0;
            r_op_start <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_load1) begin
                r_num1 <= sw;
            end
            if (w_load2) begin
                r_num2 <= sw;
            end
            if (w_load_op) begin
                r_opcode <= sw[2:0];
            end
            if (w_take_ans) begin
                r_ans <= op_result;
            end
            r_op_start <= w_enter_busy;
            r_err      <= (w_next == ST_ERROR);
        end
    end

    assign num1     = r_num1;
    assign num2     = r_num2;
    assign opcode   = r_opcode;
    assign ans      = r_ans;
    assign op_start = r_op_start;
    assign err      = r_err;
    assign state    = r_state;

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: cycle-by-cycle comparison against a
// behavioural model, plus hand-computed checks on the directed scenarios.
module tb_calc_sequencer;

    localparam int DATA_W  = 8;
    localparam int RES_W   = 10;
    localparam int TIMEOUT = 255;
    localparam int NUM_OPS = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              btnr;
    logic              btnl;
    logic [DATA_W-1:0] sw;
    logic              op_done;
    logic [RES_W-1:0]  op_result;
    logic              op_err;
    logic [DATA_W-1:0] num1;
    logic [DATA_W-1:0] num2;
    logic [2:0]        opcode;
    logic              op_start;
    logic [RES_W-1:0]  ans;
    logic [2:0]        state;
    logic              err;

    int tests = 0;
    int fails = 0;
    int start_count = 0;

    calc_sequencer #(
        .DATA_W(DATA_W), .RES_W(RES_W), .TIMEOUT(TIMEOUT), .NUM_OPS(NUM_OPS)
    ) dut (
        .clk(clk), .reset(reset), .btnr(btnr), .btnl(btnl), .sw(sw),
        .op_done(op_done), .op_result(op_result), .op_err(op_err),
        .num1(num1), .num2(num2), .opcode(opcode), .op_start(op_start),
        .ans(ans), .state(state), .err(err)
    );

    always #5 clk = ~clk;

    // Behavioural model: what the sequencer must show after each rising edge.
    int                m_state = 0;
    logic [DATA_W-1:0] m_num1 = '0;
    logic [DATA_W-1:0] m_num2 = '0;
    logic [2:0]        m_opcode = 3'd0;
    logic [RES_W-1:0]  m_ans = '0;
    logic              m_op_start = 1'b0;
    logic              m_err = 1'b0;
    logic              m_prev_r = 1'b1;
    logic              m_prev_l = 1'b1;
    int                m_busy_cycles = 0;
    bit                m_valid = 1'b0;

    always @(posedge clk) begin
        logic re;
        logic le;
        logic starting;
        starting = 1'b0;
        if (reset) begin
            m_state = 0; m_num1 = '0; m_num2 = '0; m_opcode = 3'd0; m_ans = '0;
            m_prev_r = 1'b1; m_prev_l = 1'b1; m_busy_cycles = 0;
            m_valid = 1'b1;
        end else begin
            re = btnr && !m_prev_r;
            le = btnl && !m_prev_l;
            m_prev_r = btnr;
            m_prev_l = btnl;
            if (le) begin
                m_state = 0;
            end else begin
                case (m_state)
                    0: if (re) m_state = 1;
                    1: if (re) begin m_num1 = sw; m_state = 2; end
                    2: if (re) begin m_num2 = sw; m_state = 3; end
                    3: if (re) begin
                        m_opcode = sw[2:0];
                        if (int'(sw[2:0]) < NUM_OPS) begin
                            m_state = 4; m_busy_cycles = 0; starting = 1'b1;
                        end else begin
                            m_state = 6;
                        end
                    end
                    4: begin
                        m_busy_cycles++;
                        if (op_done) begin
                            if (op_err) m_state = 6;
                            else begin m_ans = op_result; m_state = 5; end
                        end else if (m_busy_cycles == TIMEOUT + 1) begin
                            m_state = 6;
                        end
                    end
                    5: if (re) m_state = 3;
                    6: if (re) m_state = 0;
                    default: m_state = 0;
                endcase
            end
        end
        m_op_start = starting;
        m_err = (m_state == 6);
    end

    // Cycle compare of every output against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            tests++;
            if (state !== 3'(m_state) || num1 !== m_num1 || num2 !== m_num2 ||
                opcode !== m_opcode || ans !== m_ans || op_start !== m_op_start ||
                err !== m_err) begin
                fails++;
                $display("FAIL model t=%0t got st=%0d n1=%h n2=%h op=%0d ans=%h start=%b err=%b want st=%0d n1=%h n2=%h op=%0d ans=%h start=%b err=%b",
                         $time, state, num1, num2, opcode, ans, op_start, err,
                         m_state, m_num1, m_num2, m_opcode, m_ans, m_op_start, m_err);
            end
            if (op_start === 1'b1) start_count++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press_r(input logic [DATA_W-1:0] v);
        sw = v;
        btnr = 1'b1;
        tick();
        btnr = 1'b0;
        tick();
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    initial begin
        int n;
        reset = 1'b1; btnr = 1'b0; btnl = 1'b0; sw = '0;
        op_done = 1'b0; op_result = '0; op_err = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("reset_state", int'(state), 0);
        chk("reset_outs", int'({num1, num2, opcode, ans, op_start, err}), 0);

        // Basic load sequence and a 3-cycle operation.
        press_r(8'h00);
        chk("wait_to_load1", int'(state), 1);
        press_r(8'h2A);
        press_r(8'h15);
        chk("op_select", int'(state), 3);
        sw = 8'h00; btnr = 1'b1;
        tick();
        btnr = 1'b0;
        chk("busy_entry", int'(state), 4);
        chk("start_pulse", int'(op_start), 1);
        chk("num1_2A", int'(num1), 32'h2A);
        chk("num2_15", int'(num2), 32'h15);
        tick();
        chk("start_single", int'(op_start), 0);
        tick();
        op_done = 1'b1; op_result = 10'h03F;
        tick();
        op_done = 1'b0;
        chk("ans_03F", int'(ans), 32'h03F);
        chk("show", int'(state), 5);

        // Rerun from SHOW with opcode 1, then reset mid-BUSY.
        press_r(8'h01);
        chk("show_to_opsel", int'(state), 3);
        press_r(8'h01);
        chk("rerun_busy", int'(state), 4);
        chk("rerun_opcode", int'(opcode), 1);
        chk("rerun_num1", int'(num1), 32'h2A);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("reset_busy", int'({state, num1, num2, opcode, ans, op_start, err}), 0);
        op_done = 1'b1; op_result = 10'h111;
        tick();
        op_done = 1'b0;
        chk("stale_done_ignored", int'({state, ans}), 0);

        // Button held through reset deassertion.
        reset = 1'b1; btnr = 1'b1;
        tick();
        reset = 1'b0;
        tick(); tick(); tick();
        chk("held_through_reset", int'(state), 0);
        btnr = 1'b0;
        tick();

        // Illegal opcode goes to ERROR without a start pulse.
        start_count = 0;
        press_r(8'h00); press_r(8'h33); press_r(8'h44);
        press_r(8'h06);
        chk("illegal_state", int'(state), 6);
        chk("illegal_err", int'(err), 1);
        chk("illegal_no_start", start_count, 0);
        press_r(8'h00);
        chk("error_to_wait", int'({state, err}), 0);

        // Timeout: exactly TIMEOUT+1 cycles in BUSY.
        press_r(8'h00); press_r(8'h03); press_r(8'h04);
        sw = 8'h02; btnr = 1'b1;
        tick();
        btnr = 1'b0;
        n = 0;
        for (int i = 0; i < 400; i++) begin
            if (state != 3'd4) break;
            n++;
            tick();
        end
        chk("timeout_cycles", n, 256);
        chk("timeout_error", int'(state), 6);
        press_r(8'h00);

        // Good result, then an op_err run that must keep it.
        press_r(8'h00); press_r(8'h05); press_r(8'h06);
        press_r(8'h02);
        op_done = 1'b1; op_result = 10'h07A;
        tick();
        op_done = 1'b0;
        chk("ans_07A", int'(ans), 32'h07A);
        press_r(8'h03);
        sw = 8'h03; btnr = 1'b1;
        tick();
        btnr = 1'b0;
        op_done = 1'b1; op_err = 1'b1; op_result = 10'h155;
        tick();
        op_done = 1'b0; op_err = 1'b0;
        chk("operr_state", int'(state), 6);
        chk("operr_ans_kept", int'(ans), 32'h07A);
        press_r(8'h00);

        // Clear beats advance in LOAD_SECOND.
        press_r(8'h00); press_r(8'h11);
        chk("load_second", int'(state), 2);
        sw = 8'h99; btnr = 1'b1; btnl = 1'b1;
        tick();
        btnr = 1'b0; btnl = 1'b0;
        chk("clear_priority", int'(state), 0);
        chk("num2_kept", int'(num2), 32'h06);

        // Clear during BUSY, then a late op_done.
        press_r(8'h00); press_r(8'h21); press_r(8'h22);
        press_r(8'h04);
        btnl = 1'b1;
        tick();
        btnl = 1'b0;
        tick();
        op_done = 1'b1; op_result = 10'h3FF;
        tick();
        op_done = 1'b0;
        tick();
        chk("abort_wait", int'(state), 0);
        chk("abort_ans_kept", int'(ans), 32'h07A);

        // Long hold gives a single transition.
        btnr = 1'b1;
        for (int i = 0; i < 100; i++) tick();
        btnr = 1'b0;
        tick();
        chk("hold_one_edge", int'(state), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
